// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//
// Purpose : Instruction-memory request/response bundle between the fetch stage
//           and instruction memory. Requests use a req/gnt handshake; responses
//           come back in request order, flagged by imem_rvalid.
//
// Signals : imem_req    - request valid (fetch -> memory)
//           imem_addr   - request word address (fetch -> memory)
//           imem_gnt    - request accepted this cycle (memory -> fetch)
//           imem_rvalid - response data valid (memory -> fetch)
//           imem_rdata  - response instruction word (memory -> fetch)
//
// Modports: master - fetch stage side
//           slave  - instruction memory side
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose : Instruction-fetch stage feeding the IF/ID register. Owns the fetch
//           PC, issues word requests to instruction memory, buffers up to two
//           returned instructions and presents them (or a NOP bubble) to IF/ID.
//           Honours hazard stalls and execute-stage redirects.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a redirect to a non-word-aligned target raises a sticky trap
//               that halts fetching until an aligned redirect or reset.
//   undefined - redirect targets are forced word-aligned; no trap.
//
// Ports   : clk            - clock, rising edge
//           rst            - asynchronous active-low reset
//           imem           - instruction memory bus (fetch_stage_if.master)
//           StallF         - hold the presented instruction (no pop)
//           PCSrcE         - redirect taken in execute this cycle
//           PCTargetE      - redirect target
//           PCF            - PC of the presented instruction
//           InstrF         - presented instruction (NOP_INSTR when none)
//           PCPlus4F       - PCF + 4
//           ValidF         - InstrF is a real fetched instruction
//           InstrMisalignF - sticky misaligned-redirect trap
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 StallF,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrF,
    output logic [31:0]          PCPlus4F,
    output logic                 ValidF,
    output logic                 InstrMisalignF
);

    // Control state
    logic [31:0] r_fpc;         // next address to request
    logic [1:0]  r_out_cnt;     // granted, not yet returned
    logic [1:0]  r_drop_cnt;    // in-flight responses to discard
    logic [1:0]  r_buf_cnt;     // valid FIFO entries
    logic        r_head;
    logic        r_tail;
    logic        r_iq_head;
    logic        r_iq_tail;
    logic        r_trap;

    // Storage
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_iq_pc     [2];  // addresses of granted requests, in order

    logic        w_rvalid;
    logic        w_drop_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;
    logic        w_req;
    logic        w_grant;
    logic        w_misalign;
    logic [1:0]  w_live;
    logic [2:0]  w_occ;
    logic [31:0] w_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target       = PCTargetE;
    assign w_misalign     = (PCTargetE[1:0] != 2'b00);
    assign InstrMisalignF = r_trap;
`else
    assign w_target       = PCTargetE & ~32'h0000_0003;
    assign w_misalign     = 1'b0;
    assign InstrMisalignF = 1'b0;
`endif

    // A response with nothing outstanding is a memory-side error; ignore it
    // so the counters can never wrap.
    assign w_rvalid   = imem.imem_rvalid && (r_out_cnt != 2'd0);
    assign w_drop_rsp = w_rvalid && (r_drop_cnt != 2'd0);
    assign w_push     = w_rvalid && !w_drop_rsp && !PCSrcE;

    assign w_valid    = (r_buf_cnt != 2'd0) && !r_trap;
    assign w_pop      = w_valid && !StallF && !PCSrcE;

    // Credit: buffered entries plus live (non-dropped) requests must stay
    // below the FIFO depth. An entry popped this cycle frees its slot now,
    // which is what sustains one instruction per cycle with zero-wait memory.
    assign w_live  = r_out_cnt - r_drop_cnt;
    assign w_occ   = {1'b0, r_buf_cnt} + {1'b0, w_live} - {2'b00, w_pop};
    assign w_req   = !PCSrcE && !r_trap && (r_out_cnt < 2'd2) && (w_occ < 3'd2);
    assign w_grant = w_req && imem.imem_gnt;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fpc;

    assign ValidF   = w_valid;
    assign PCF      = w_valid ? r_buf_pc[r_head]    : r_fpc;
    assign InstrF   = w_valid ? r_buf_instr[r_head] : NOP_INSTR;
    assign PCPlus4F = PCF + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_out_cnt  <= 2'd0;
            r_drop_cnt <= 2'd0;
            r_buf_cnt  <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_iq_head  <= 1'b0;
            r_iq_tail  <= 1'b0;
            r_trap     <= 1'b0;
        end else if (PCSrcE) begin
            // Redirect: flush the buffer; every response still in flight is
            // stale. One returning this very cycle is discarded right away.
            r_fpc      <= w_target;
            r_buf_cnt  <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_trap     <= w_misalign;
            r_out_cnt  <= r_out_cnt - {1'b0, w_rvalid};
            r_drop_cnt <= r_out_cnt - {1'b0, w_rvalid};
            if (w_rvalid) begin
                r_iq_head <= ~r_iq_head;
            end
        end else begin
            if (w_grant) begin
                r_fpc     <= r_fpc + 32'd4;
                r_iq_tail <= ~r_iq_tail;
            end
            if (w_rvalid) begin
                r_iq_head <= ~r_iq_head;
            end
            r_out_cnt <= r_out_cnt + {1'b0, w_grant} - {1'b0, w_rvalid};
            if (w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - 2'd1;
            end
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // NOTE: storage arrays are not reset; their contents are only observed
    // through entries the counters mark valid.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_iq_pc[r_iq_tail] <= r_fpc;
        end
        if (w_push) begin
            r_buf_pc[r_tail]    <= r_iq_pc[r_iq_head];
            r_buf_instr[r_tail] <= imem.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory returns addr ^ KEY.
// Memory behaviour (grant delay, response hold-off) is controlled per step.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        InstrMisalignF;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus.master),
        .StallF         (StallF),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .PCF            (PCF),
        .InstrF         (InstrF),
        .PCPlus4F       (PCPlus4F),
        .ValidF         (ValidF),
        .InstrMisalignF (InstrMisalignF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    logic [31:0] rsp_q [$];
    bit          auto_rsp  = 1'b1;
    int          gnt_delay = 0;
    int          wait_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory inputs, step through the rising edge,
    // update the memory model and return just after the falling edge.
    task automatic tick();
        logic        rv;
        logic        g;
        logic        rq;
        logic [31:0] a;
        rv = auto_rsp && (rsp_q.size() != 0);
        imem_bus.imem_rvalid = rv;
        imem_bus.imem_rdata  = rv ? (rsp_q[0] ^ KEY) : 32'h0;
        #1;
        rq = imem_bus.imem_req;
        g  = rq && (wait_cnt >= gnt_delay);
        imem_bus.imem_gnt = g;
        a  = imem_bus.imem_addr;
        #1;
        @(posedge clk);
        if (rv) void'(rsp_q.pop_front());
        if (g) rsp_q.push_back(a);
        wait_cnt = (rq && !g) ? wait_cnt + 1 : 0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        StallF    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;

        // Reset state
        check("rst_valid",    ValidF,         0);
        check("rst_instr",    InstrF,         NOP);
        check("rst_pcf",      PCF,            32'h0);
        check("rst_pcplus4",  PCPlus4F,       32'h4);
        check("rst_req",      imem_bus.imem_req,  1);
        check("rst_addr",     imem_bus.imem_addr, 32'h0);
        check("rst_misalign", InstrMisalignF, 0);

        // Zero-wait streaming: ValidF rises in cycle 2
        tick();
        check("c1_valid", ValidF, 0);
        check("c1_pcf",   PCF,    32'h4);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check("walk_valid", ValidF, 1);
            check("walk_pcf",   PCF,    32'((k - 2) * 4));
            check("walk_instr", InstrF, 32'((k - 2) * 4) ^ KEY);
        end
        check("walk_pcplus4", PCPlus4F, 32'd24);
        check("walk_addr",    imem_bus.imem_addr, 32'd28);

        // Stall 4 cycles: output frozen, requests stop once credit is used
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_pcf",   PCF,    32'd20);
            check("stall_instr", InstrF, 32'd20 ^ KEY);
            check("stall_req",   imem_bus.imem_req, 0);
        end
        StallF = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("resume_valid", ValidF, 1);
            check("resume_pcf",   PCF,    32'(24 + 4 * k));
            check("resume_instr", InstrF, 32'(24 + 4 * k) ^ KEY);
        end

        // Grant delayed 3 cycles per request
        gnt_delay = 3;
        tick();
        check("gd1_pcf",   PCF, 32'd40);
        tick();
        check("gd2_valid", ValidF, 0);
        check("gd2_instr", InstrF, NOP);
        check("gd2_req",   imem_bus.imem_req,  1);
        check("gd2_addr",  imem_bus.imem_addr, 32'd44);
        tick();
        check("gd3_req",   imem_bus.imem_req,  1);
        check("gd3_addr",  imem_bus.imem_addr, 32'd44);
        tick();
        check("gd4_valid", ValidF, 0);
        check("gd4_addr",  imem_bus.imem_addr, 32'd48);
        tick();
        check("gd5_valid", ValidF, 1);
        check("gd5_pcf",   PCF,    32'd44);
        check("gd5_instr", InstrF, 32'd44 ^ KEY);
        tick();
        check("gd6_valid", ValidF, 0);
        check("gd6_addr",  imem_bus.imem_addr, 32'd48);
        tick();
        check("gd7_addr",  imem_bus.imem_addr, 32'd48);
        tick();
        check("gd8_addr",  imem_bus.imem_addr, 32'd52);
        tick();
        check("gd9_pcf",   PCF, 32'd48);
        gnt_delay = 0;
        tick();
        check("gd10_valid", ValidF, 0);
        check("gd10_pcf",   PCF,    32'd56);
        tick();
        check("gd11_pcf",   PCF,    32'd52);

        // Two requests in flight, then redirect to 0x100
        auto_rsp = 1'b0;
        tick();
        check("inflight_valid", ValidF, 0);
        check("inflight_req",   imem_bus.imem_req, 0);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0;
        #1;
        check("redir_pcf",   PCF,    32'h100);
        check("redir_valid", ValidF, 0);
        check("redir_req",   imem_bus.imem_req, 0);
        auto_rsp = 1'b1;
        tick();
        check("drop_req",  imem_bus.imem_req,  1);
        check("drop_addr", imem_bus.imem_addr, 32'h100);
        tick();
        check("drop_valid", ValidF, 0);
        tick();
        check("tgt_valid", ValidF, 1);
        check("tgt_pcf",   PCF,    32'h100);
        check("tgt_instr", InstrF, 32'h100 ^ KEY);

        // Redirect coinciding with rvalid while stalled
        StallF    = 1'b1;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        tick();
        StallF = 1'b0;
        PCSrcE = 1'b0;
        #1;
        check("rs_valid", ValidF, 0);
        check("rs_pcf",   PCF,    32'h200);
        check("rs_instr", InstrF, NOP);
        check("rs_req",   imem_bus.imem_req,  1);
        check("rs_addr",  imem_bus.imem_addr, 32'h200);
        tick();
        check("rs2_valid", ValidF, 0);
        tick();
        check("rs3_valid", ValidF, 1);
        check("rs3_pcf",   PCF,    32'h200);
        check("rs3_instr", InstrF, 32'h200 ^ KEY);

        // Misaligned redirect target
        PCSrcE    = 1'b1;
        PCTargetE = 32'h102;
        tick();
        PCSrcE = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag",  InstrMisalignF, 1);
        check("mis_req",   imem_bus.imem_req, 0);
        check("mis_pcf",   PCF,    32'h102);
        check("mis_valid", ValidF, 0);
        tick();
        check("mis_sticky", InstrMisalignF, 1);
        check("mis_req2",   imem_bus.imem_req, 0);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        #1;
        check("clr_flag", InstrMisalignF, 0);
        check("clr_req",  imem_bus.imem_req,  1);
        check("clr_addr", imem_bus.imem_addr, 32'h200);
        tick();
        tick();
        check("clr_valid", ValidF, 1);
        check("clr_pcf",   PCF,    32'h200);
`else
        check("align_flag", InstrMisalignF, 0);
        check("align_pcf",  PCF,    32'h100);
        check("align_req",  imem_bus.imem_req,  1);
        check("align_addr", imem_bus.imem_addr, 32'h100);
        tick();
        tick();
        check("align_valid", ValidF, 1);
        check("align_pcf2",  PCF,    32'h100);
        check("align_instr", InstrF, 32'h100 ^ KEY);
`endif

        // Asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        rsp_q.delete();
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_gnt    = 1'b0;
        check("arst_valid", ValidF, 0);
        check("arst_pcf",   PCF,    32'h0);
        check("arst_instr", InstrF, NOP);
        check("arst_req",   imem_bus.imem_req,  1);
        check("arst_addr",  imem_bus.imem_addr, 32'h0);
        check("arst_misalign", InstrMisalignF, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
